gpr_wr_arbiter: RTL and testbench

//  Shares the GPR's single write port (WE/AWr/Din) and flag-update path (FlagOp/NFlag) between two writers.
//  - Port 0: main pipeline writeback.
//  - Port 1: multi-cycle unit (mult/div, late load).

---
 rtl/gpr_wr_arbiter.sv | 116 +++++++++++
 tb/tb_gpr_wr_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wr_arbiter.sv
// Two-writer arbiter in front of the GPR write/flag port: one grant per cycle,
// winner registered onto the GPR inputs, port 1 forced through after MAX_WAIT refusals.
module gpr_wr_arbiter #(
  parameter int unsigned MAX_WAIT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb0_valid,
  input  logic [4:0]       wb0_addr,
  input  logic [31:0]      wb0_data,
  input  logic             wb0_fset,
  input  logic [31:0]      wb0_nflag,
  output logic             wb0_ready,
  input  logic             wb1_valid,
  input  logic [4:0]       wb1_addr,
  input  logic [31:0]      wb1_data,
  input  logic             wb1_fset,
  input  logic [31:0]      wb1_nflag,
  output logic             wb1_ready,
  output logic             WE,
  output logic [4:0]       AWr,
  output logic [31:0]      Din,
  output logic [1:0]       FlagOp,
  output logic [31:0]      NFlag,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {
    WR_DIS = 1'b0,
    WR_EN  = 1'b1
  } wr_e;

  typedef enum logic [1:0] {
    FLAG_OP_DIS        = 2'd0,
    FLAG_OP_SET        = 2'd1,
    FLAG_OP_SET_AND_WR = 2'd2
  } flag_op_e;

  localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [WW-1:0] wait_cnt;
  logic          force1;
  logic          grant0;
  logic          grant1;
  logic [4:0]    sel_addr;
  logic [31:0]   sel_data;
  logic          sel_fset;
  logic [31:0]   sel_nflag;
  wr_e           we_q;
  flag_op_e      fop_q;

  assign force1    = (wait_cnt == WW'(MAX_WAIT));
  assign grant1    = wb1_valid && (force1 || !wb0_valid);
  assign grant0    = wb0_valid && !grant1;
  assign wb0_ready = grant0;
  assign wb1_ready = grant1;
  assign WE        = we_q;
  assign FlagOp    = fop_q;

  always_comb begin
    sel_addr  = wb0_addr;
    sel_data  = wb0_data;
    sel_fset  = wb0_fset;
    sel_nflag = wb0_nflag;
    if (grant1) begin
      sel_addr  = wb1_addr;
      sel_data  = wb1_data;
      sel_fset  = wb1_fset;
      sel_nflag = wb1_nflag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q  <= WR_DIS;
      fop_q <= FLAG_OP_DIS;
      AWr   <= '0;
      Din   <= '0;
      NFlag <= '0;
    end else if (grant0 || grant1) begin
      // $0 is never written; a flag-only update still goes through as SET
      we_q  <= (sel_addr != '0) ? WR_EN : WR_DIS;
      if (!sel_fset)
        fop_q <= FLAG_OP_DIS;
      else if (sel_addr != '0)
        fop_q <= FLAG_OP_SET_AND_WR;
      else
        fop_q <= FLAG_OP_SET;
      AWr   <= sel_addr;
      Din   <= sel_data;
      NFlag <= sel_nflag;
    end else begin
      we_q  <= WR_DIS;
      fop_q <= FLAG_OP_DIS;
    end
  end

  // force1 always grants port 1, so the increment can never pass MAX_WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if (wb1_valid && grant0)
      wait_cnt <= wait_cnt + 1'b1;
    else
      wait_cnt <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      conflict_cnt <= '0;
    else if (wb0_valid && wb1_valid && (conflict_cnt != '1))
      conflict_cnt <= conflict_cnt + 1'b1;
  end

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Bench for gpr_wr_arbiter: table of request vectors with expected grants, and a
// queue of expected GPR-side outputs checked one cycle after each grant decision.
module tb_gpr_wr_arbiter;

  localparam logic [1:0] FOP_DIS = 2'd0;
  localparam logic [1:0] FOP_SET = 2'd1;
  localparam logic [1:0] FOP_SAW = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb0_valid, wb0_fset, wb0_ready;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data, wb0_nflag;
  logic        wb1_valid, wb1_fset, wb1_ready;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data, wb1_nflag;
  logic        WE;
  logic [4:0]  AWr;
  logic [31:0] Din, NFlag;
  logic [1:0]  FlagOp;
  logic [15:0] conflict_cnt;

  logic        s_we, s_r0, s_r1;
  logic [4:0]  s_awr;
  logic [31:0] s_din, s_nflag;
  logic [1:0]  s_fop;
  logic [3:0]  s_cnt;

  gpr_wr_arbiter #(.MAX_WAIT(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb0_fset(wb0_fset), .wb0_nflag(wb0_nflag), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .wb1_fset(wb1_fset), .wb1_nflag(wb1_nflag), .wb1_ready(wb1_ready),
    .WE(WE), .AWr(AWr), .Din(Din), .FlagOp(FlagOp), .NFlag(NFlag),
    .conflict_cnt(conflict_cnt)
  );

  gpr_wr_arbiter #(.MAX_WAIT(3), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb0_fset(wb0_fset), .wb0_nflag(wb0_nflag), .wb0_ready(s_r0),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .wb1_fset(wb1_fset), .wb1_nflag(wb1_nflag), .wb1_ready(s_r1),
    .WE(s_we), .AWr(s_awr), .Din(s_din), .FlagOp(s_fop), .NFlag(s_nflag),
    .conflict_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        f0;
    logic [31:0] n0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        f1;
    logic [31:0] n1;
    logic        r0;
    logic        r1;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  awr;
    logic [31:0] din;
    logic [1:0]  fop;
    logic [31:0] nflag;
  } exp_t;

  vec_t        tbl[$];
  exp_t        expq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_cnt;
  int          m_cnt4;
  logic [4:0]  h_awr;
  logic [31:0] h_din, h_nflag;
  string       tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s [%s]: got %h, expected %h", name, tag, act, req);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic f0, input logic [31:0] n0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic f1, input logic [31:0] n1,
                              input logic r0, input logic r1);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.f0 = f0; v.n0 = n0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1; v.f1 = f1; v.n1 = n1;
    v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  // k-th cycle of continuous contention from wait_cnt=0: port 1 wins every 4th cycle,
  // each port keeps its payload until it has been granted
  function automatic vec_t cont(input int k);
    int p0 = k - k / 4;
    return mk(1'b1, 5'(1 + p0 % 16), 32'h0000_1000 + 32'(p0), 1'b0, 32'h0,
              1'b1, 5'd21, 32'hA1A1_0000 + 32'(k / 4), 1'b0, 32'h0,
              (k % 4) != 3, (k % 4) == 3);
  endfunction

  function automatic exp_t map(input logic [4:0] a, input logic [31:0] d,
                               input logic f, input logic [31:0] n);
    exp_t e;
    e.we    = (a != 5'd0);
    e.fop   = !f ? FOP_DIS : ((a != 5'd0) ? FOP_SAW : FOP_SET);
    e.awr   = a;
    e.din   = d;
    e.nflag = n;
    return e;
  endfunction

  task automatic model_reset();
    expq.delete();
    m_cnt = 0; m_cnt4 = 0;
    h_awr = '0; h_din = '0; h_nflag = '0;
    expq.push_back(map(5'd0, 32'h0, 1'b0, 32'h0));
  endtask

  task automatic check_outputs();
    exp_t e;
    if (expq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard [%s]: got empty queue, expected an entry", tag);
      return;
    end
    e = expq.pop_front();
    chk("WE", 32'(WE), 32'(e.we));
    chk("AWr", 32'(AWr), 32'(e.awr));
    chk("Din", Din, e.din);
    chk("FlagOp", 32'(FlagOp), 32'(e.fop));
    chk("NFlag", NFlag, e.nflag);
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    chk("conflict_cnt_w4", 32'(s_cnt), 32'(m_cnt4));
  endtask

  task automatic drive(input vec_t v);
    wb0_valid = v.v0; wb0_addr = v.a0; wb0_data = v.d0; wb0_fset = v.f0; wb0_nflag = v.n0;
    wb1_valid = v.v1; wb1_addr = v.a1; wb1_data = v.d1; wb1_fset = v.f1; wb1_nflag = v.n1;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    check_outputs();
    drive(v);
    #1;
    chk("wb0_ready", 32'(wb0_ready), 32'(v.r0));
    chk("wb1_ready", 32'(wb1_ready), 32'(v.r1));
    if (v.r0)
      e = map(v.a0, v.d0, v.f0, v.n0);
    else if (v.r1)
      e = map(v.a1, v.d1, v.f1, v.n1);
    else begin
      e = map(h_awr, h_din, 1'b0, h_nflag);
      e.we = 1'b0;
    end
    h_awr = e.awr; h_din = e.din; h_nflag = e.nflag;
    expq.push_back(e);
    if (v.v0 && v.v1) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  initial begin
    vec_t idle;
    idle = mk(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    tbl.push_back(idle);
    tbl.push_back(mk(1'b1, 5'd20, 32'hFEDC_1234, 1'b0, 32'h0,
                     1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
    tbl.push_back(idle);
    for (int k = 0; k < 8; k++) tbl.push_back(cont(k));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 32'h0,
                     1'b1, 5'd0, 32'h5555_AAAA, 1'b1, 32'h1234_CDEF, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 5'd21, 32'h9876_5432, 1'b1, 32'h1212_3434,
                     1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'd0, 32'h2345_6789, 1'b0, 32'h0,
                     1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 32'h0,
                     1'b1, 5'd7, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0, 1'b1));
    tbl.push_back(idle);
    tbl.push_back(idle);

    tag = "reset";
    drive(idle);
    reset = 1'b1;
    #3;
    chk("WE", 32'(WE), 32'h0);
    chk("FlagOp", 32'(FlagOp), 32'(FOP_DIS));
    chk("conflict_cnt", 32'(conflict_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    foreach (tbl[i]) begin
      tag = $sformatf("row %0d", i);
      apply(tbl[i]);
    end

    // Build up wait_cnt, then reset with a write in flight
    tag = "pre-reset contention";
    for (int k = 0; k < 3; k++) apply(cont(k));
    tag = "reset mid-transfer";
    @(posedge clk);
    #2;
    chk("WE in flight", 32'(WE), 32'h1);
    reset = 1'b1;
    drive(idle);
    #1;
    chk("WE", 32'(WE), 32'h0);
    chk("FlagOp", 32'(FlagOp), 32'(FOP_DIS));
    chk("AWr", 32'(AWr), 32'h0);
    chk("conflict_cnt", 32'(conflict_cnt), 32'h0);
    chk("conflict_cnt_w4", 32'(s_cnt), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // wait_cnt must restart from 0, then counters run into saturation on the narrow copy
    for (int k = 0; k < 24; k++) begin
      tag = $sformatf("post-reset contention %0d", k);
      apply(cont(k));
    end
    tag = "drain";
    apply(idle);
    @(negedge clk);
    check_outputs();
    chk("conflict_cnt final", 32'(conflict_cnt), 32'd24);
    chk("conflict_cnt_w4 saturated", 32'(s_cnt), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
